// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end sharing one free-running CORDIC sin/cos pipeline between N_CH requesters.
// A tag shift register follows each sample through the pipe; per-channel credits cap in-flight samples.
module cordic_rr_scheduler #(
  parameter int N_CH         = 4,
  parameter int ARG_WIDTH    = 16,
  parameter int DAT_WIDTH    = 14,
  parameter int CORDIC_LAT   = 15,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*ARG_WIDTH-1:0] arg_in,
  output logic [N_CH-1:0]           gnt,
  output logic [ARG_WIDTH-1:0]      cordic_arg,
  input  logic [DAT_WIDTH-1:0]      cordic_re,
  input  logic [DAT_WIDTH-1:0]      cordic_im,
  output logic                      res_valid,
  output logic [$clog2(N_CH)-1:0]   res_ch,
  output logic [DAT_WIDTH-1:0]      res_re,
  output logic [DAT_WIDTH-1:0]      res_im,
  output logic                      busy
);

  localparam int CW    = $clog2(N_CH);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int TAGS  = CORDIC_LAT + 1;

  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q [N_CH];
  logic [CNT_W-1:0]     cnt_d [N_CH];
  logic [TAGS-1:0]      tag_v_q;
  logic [CW-1:0]        tag_ch_q [TAGS];
  logic [ARG_WIDTH-1:0] cordic_arg_q;
  logic                 res_valid_q;
  logic [CW-1:0]        res_ch_q;
  logic [DAT_WIDTH-1:0] res_re_q, res_im_q;

  logic [N_CH-1:0]      eligible;
  logic                 found;
  logic [CW-1:0]        gnt_idx;
  logic                 ret_v;
  logic [CW-1:0]        ret_ch;

  assign ret_v  = tag_v_q[TAGS-1];
  assign ret_ch = tag_ch_q[TAGS-1];

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      eligible[i] = req[i] && (cnt_q[i] < CNT_W'(MAX_INFLIGHT));
    end
  end

  // Search starts at rr_ptr and wraps; the first eligible channel wins.
  always_comb begin : arb
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = CW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
    end
  end

  // A same-cycle grant and retire for one channel cancel out.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !(ret_v && ret_ch == CW'(i))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!gnt[i] && ret_v && ret_ch == CW'(i)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      cordic_arg_q <= '0;
      tag_v_q      <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_re_q     <= '0;
      res_im_q     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      for (int unsigned j = 0; j < TAGS; j++) tag_ch_q[j] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      if (found) cordic_arg_q <= arg_in[gnt_idx*ARG_WIDTH +: ARG_WIDTH];
      tag_v_q     <= {tag_v_q[TAGS-2:0], found};
      tag_ch_q[0] <= gnt_idx;
      for (int unsigned j = 1; j < TAGS; j++) tag_ch_q[j] <= tag_ch_q[j-1];
      res_valid_q <= ret_v;
      if (ret_v) begin
        res_ch_q <= ret_ch;
        res_re_q <= cordic_re;
        res_im_q <= cordic_im;
      end
    end
  end

  assign cordic_arg = cordic_arg_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_re     = res_re_q;
  assign res_im     = res_im_q;
  assign busy       = (|tag_v_q) | res_valid_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: a behavioural CORDIC delay model feeds results back;
// expected results are queued at grant time and checked by an independent monitor.
module tb_cordic_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] arg_in;
  logic [3:0]  gnt;
  logic [15:0] cordic_arg;
  logic [13:0] cordic_re, cordic_im;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [13:0] res_re, res_im;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int post_rst_rv = 0;
  logic count_rv = 1'b0;

  typedef struct {
    int                 due;
    logic [1:0]         ch;
    logic signed [13:0] re;
    logic signed [13:0] im;
  } exp_t;
  exp_t sb[$];

  cordic_rr_scheduler #(
    .N_CH(4), .ARG_WIDTH(16), .DAT_WIDTH(14), .CORDIC_LAT(15), .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .arg_in(arg_in), .gnt(gnt),
    .cordic_arg(cordic_arg), .cordic_re(cordic_re), .cordic_im(cordic_im),
    .res_valid(res_valid), .res_ch(res_ch), .res_re(res_re), .res_im(res_im),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy CORDIC: signs follow the quadrant, magnitudes tagged by low angle bits.
  function automatic logic [27:0] cfn(input logic [15:0] a);
    logic signed [13:0] mr, mi, re, im;
    mr = 14'(32'd1000 + 32'(a[7:0]));
    mi = 14'(32'd2000 + 32'(a[9:2]));
    re = (a[15:14] == 2'd0 || a[15:14] == 2'd3) ? mr : -mr;
    im = (a[15] == 1'b0) ? mi : -mi;
    return {re, im};
  endfunction

  logic [15:0] cpipe [15];
  always @(posedge clk) begin
    cpipe[0] <= cordic_arg;
    for (int k = 1; k < 15; k++) cpipe[k] <= cpipe[k-1];
  end
  assign {cordic_re, cordic_im} = cfn(cpipe[14]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One stimulus cycle: drive, check combinational grant, queue expected result.
  task automatic issue(input logic [3:0] r, input logic [63:0] a, input logic [3:0] eg,
                       input logic use_hand, input logic signed [13:0] hr,
                       input logic signed [13:0] hi);
    exp_t e;
    logic [27:0] m;
    @(posedge clk); #1;
    req = r; arg_in = a;
    #2;
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        m     = cfn(a[i*16 +: 16]);
        e.due = cyc + 17;
        e.ch  = 2'(i);
        e.re  = use_hand ? hr : m[27:14];
        e.im  = use_hand ? hi : m[13:0];
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(4'b0000, 64'd0, 4'b0000, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req = '0; rst_n = 1'b0; sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (count_rv) post_rst_rv++;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL result: unexpected res_valid ch=%0d at cycle %0d", res_ch, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.due == cyc && e.ch == res_ch && e.re == res_re && e.im == res_im) passed++;
        else $display("FAIL result: got cyc=%0d ch=%0d re=%0d im=%0d, want cyc=%0d ch=%0d re=%0d im=%0d",
                      cyc, res_ch, $signed(res_re), $signed(res_im), e.due, e.ch, e.re, e.im);
      end
    end
  end

  localparam logic [63:0] ARGS4 = {16'h0C30, 16'h0820, 16'h0410, 16'h0000};

  initial begin
    rst_n = 1'b0; req = '0; arg_in = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst cordic_arg", {16'd0, cordic_arg}, 32'd0);
    chk("rst res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst res_ch", {30'd0, res_ch}, 32'd0);
    chk("rst res_re", {18'd0, res_re}, 32'd0);
    chk("rst res_im", {18'd0, res_im}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single request on ch1, busy window 1..17 relative to grant cycle
    issue(4'b0010, 64'd0, 4'b0010, 1'b1, 14'sd1000, 14'sd2000);
    for (int k = 1; k <= 18; k++) begin
      issue(4'b0000, 64'd0, 4'b0000, 1'b0, '0, '0);
      chk($sformatf("busy+%0d", k), {31'd0, busy}, {31'd0, (k <= 17)});
    end
    idle(2);

    // All four requesting: strict rotation
    do_reset();
    for (int k = 0; k < 8; k++) issue(4'b1111, ARGS4, 4'(1 << (k % 4)), 1'b0, '0, '0);
    idle(22);

    // Credit limit on ch2
    do_reset();
    for (int k = 0; k < 22; k++)
      issue(4'b0100, ARGS4, ((k < 4) || (k >= 17 && k <= 20)) ? 4'b0100 : 4'b0000, 1'b0, '0, '0);
    idle(22);

    // Fairness with rr_ptr parked at 2
    do_reset();
    issue(4'b0010, ARGS4, 4'b0010, 1'b0, '0, '0);
    issue(4'b1011, ARGS4, 4'b1000, 1'b0, '0, '0);
    issue(4'b1011, ARGS4, 4'b0001, 1'b0, '0, '0);
    issue(4'b1011, ARGS4, 4'b0010, 1'b0, '0, '0);
    issue(4'b1011, ARGS4, 4'b1000, 1'b0, '0, '0);
    idle(22);

    // Quadrant sweep on ch0
    do_reset();
    issue(4'b0001, {48'd0, 16'h2000}, 4'b0001, 1'b1,  14'sd1000,  14'sd2000);
    issue(4'b0001, {48'd0, 16'h6000}, 4'b0001, 1'b1, -14'sd1000,  14'sd2000);
    issue(4'b0001, {48'd0, 16'hA000}, 4'b0001, 1'b1, -14'sd1000, -14'sd2000);
    issue(4'b0001, {48'd0, 16'hE000}, 4'b0001, 1'b1,  14'sd1000, -14'sd2000);
    idle(22);

    // Mid-stream reset while results are emerging
    do_reset();
    for (int k = 0; k < 18; k++)
      issue(4'b1111, ARGS4, (k < 16) ? 4'(1 << (k % 4)) : ((k == 17) ? 4'b0001 : 4'b0000),
            1'b0, '0, '0);
    @(posedge clk); #1;
    req = '0;
    #2;
    rst_n = 1'b0; sb.delete();
    #1;
    chk("midrst res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst cordic_arg", {16'd0, cordic_arg}, 32'd0);
    chk("midrst res_ch", {30'd0, res_ch}, 32'd0);
    chk("midrst res_re", {18'd0, res_re}, 32'd0);
    chk("midrst gnt", {28'd0, gnt}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    count_rv = 1'b1;
    idle(30);
    count_rv = 1'b0;
    chk("post-reset results", post_rst_rv, 32'd0);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
